axi_light_rr_arbiter: RTL

//  Shares a single AXI-light slave port (memory_controller) between NUM_MASTERS AXI-light masters
//  (controller + processing nodes). Round-robin, one outstanding transaction system-wide.

---
 rtl/axi_light_rr_arbiter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_light_rr_arbiter.sv
// axi_light_rr_arbiter
//
// Shares one AXI-light slave port (the memory controller) between NUM_MASTERS
// AXI-light masters. Round-robin arbitration with exactly one transaction in
// flight system-wide: the granted master owns the slave from its address
// phase until its B or R response completes. Writes and reads are serialised
// through a single FSM.
//
// Ports
//   clk, res_n                      clock, synchronous active-low reset
//   m_aw*/m_w*/m_b*/m_ar*/m_r*      per-master channels, packed; master i owns
//                                   slice [i*W +: W] / bit [i]
//   m_rdata                         shared read data, qualified by m_rvalid
//   s_aw*/s_w*/s_b*/s_ar*/s_r*      single slave-side channel set
//   grant_id                        index of the current owner (valid while busy)
//   busy                            high whenever the FSM is not idle
module axi_light_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 1
) (
  input  logic                                clk,
  input  logic                                res_n,
  // master side
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_awaddr,
  input  logic [NUM_MASTERS-1:0]              m_awvalid,
  output logic [NUM_MASTERS-1:0]              m_awready,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_wstrb,
  input  logic [NUM_MASTERS-1:0]              m_wvalid,
  output logic [NUM_MASTERS-1:0]              m_wready,
  output logic [NUM_MASTERS-1:0]              m_bvalid,
  input  logic [NUM_MASTERS-1:0]              m_bready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_araddr,
  input  logic [NUM_MASTERS-1:0]              m_arvalid,
  output logic [NUM_MASTERS-1:0]              m_arready,
  output logic [DATA_WIDTH-1:0]               m_rdata,
  output logic [NUM_MASTERS-1:0]              m_rvalid,
  input  logic [NUM_MASTERS-1:0]              m_rready,
  // slave side
  output logic [ADDR_WIDTH-1:0]               s_awaddr,
  output logic                                s_awvalid,
  input  logic                                s_awready,
  output logic [DATA_WIDTH-1:0]               s_wdata,
  output logic [DATA_WIDTH/8-1:0]             s_wstrb,
  output logic                                s_wvalid,
  input  logic                                s_wready,
  input  logic                                s_bvalid,
  output logic                                s_bready,
  output logic [ADDR_WIDTH-1:0]               s_araddr,
  output logic                                s_arvalid,
  input  logic                                s_arready,
  input  logic [DATA_WIDTH-1:0]               s_rdata,
  input  logic                                s_rvalid,
  output logic                                s_rready,
  // status
  output logic [ID_WIDTH-1:0]                 grant_id,
  output logic                                busy
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_ADDR = 3'd1,
    W_DATA = 3'd2,
    W_RESP = 3'd3,
    R_ADDR = 3'd4,
    R_RESP = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_MASTERS-1:0] req;
  logic                   hi_found, lo_found;
  logic [ID_WIDTH-1:0]    hi_id, lo_id;
  logic                   win_valid;
  logic [ID_WIDTH-1:0]    win_id;
  logic                   win_aw;
  logic [ID_WIDTH-1:0]    next_ptr;

  // Round-robin search. Masters at or above rr_ptr form the "hi" group and
  // take precedence over the wrapped-around "lo" group; within a group the
  // lowest index wins. Scanning downwards and overwriting leaves the lowest
  // requesting index in each group.
  always_comb begin
    req      = m_awvalid | m_arvalid;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    win_aw   = 1'b0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (ID_WIDTH'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_id    = ID_WIDTH'(i);
        end else begin
          lo_found = 1'b1;
          lo_id    = ID_WIDTH'(i);
        end
      end
    end
    win_valid = hi_found | lo_found;
    win_id    = hi_found ? hi_id : lo_id;
    // A write request beats a read request from the same master.
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (ID_WIDTH'(i) == win_id) begin
        win_aw = m_awvalid[i];
      end
    end
  end

  // Explicit wrap so NUM_MASTERS need not be a power of two.
  always_comb begin
    if (grant_id_q == ID_WIDTH'(NUM_MASTERS - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = grant_id_q + ID_WIDTH'(1);
    end
  end

  // Forwarding: only the grantee is connected, and only the channel that
  // belongs to the current state. Everything else is held at zero so the
  // memory controller never sees stale or undefined address/data.
  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_arready = '0;
    m_rvalid  = '0;
    m_rdata   = '0;
    s_awaddr  = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    s_araddr  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (ID_WIDTH'(i) == grant_id_q) begin
        case (state_q)
          W_ADDR: begin
            s_awaddr     = m_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            s_awvalid    = m_awvalid[i];
            m_awready[i] = s_awready;
          end
          W_DATA: begin
            s_wdata     = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            s_wstrb     = m_wstrb[i*STRB_W +: STRB_W];
            s_wvalid    = m_wvalid[i];
            m_wready[i] = s_wready;
          end
          W_RESP: begin
            m_bvalid[i] = s_bvalid;
            s_bready    = m_bready[i];
          end
          R_ADDR: begin
            s_araddr     = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            s_arvalid    = m_arvalid[i];
            m_arready[i] = s_arready;
          end
          R_RESP: begin
            m_rvalid[i] = s_rvalid;
            s_rready    = m_rready[i];
            m_rdata     = s_rdata;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Next-state logic. Arbitration takes the single IDLE cycle; every other
  // state advances only on its own channel handshake.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          grant_id_d = win_id;
          state_d    = win_aw ? W_ADDR : R_ADDR;
        end
      end
      W_ADDR: if (s_awvalid && s_awready) state_d = W_DATA;
      W_DATA: if (s_wvalid && s_wready) state_d = W_RESP;
      W_RESP: begin
        if (s_bvalid && s_bready) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      R_ADDR: if (s_arvalid && s_arready) state_d = R_RESP;
      R_RESP: begin
        if (s_rvalid && s_rready) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q != IDLE);

endmodule
